// File: rtl/watch_set_cu_if.sv
// Button/tick inputs and set-mode control outputs between the watch top and its set control unit.
// The master drives the button pulses and tick; the slave (watch_set_cu) drives the control outputs.
interface watch_set_cu_if;
    logic       i_mode;
    logic       i_next;
    logic       i_up;
    logic       i_down;
    logic       i_tick_1hz;
    logic       o_run;
    logic       o_set_mode;
    logic [1:0] o_field;
    logic       o_inc;
    logic       o_dec;
    logic       o_blank;

    modport master (
        output i_mode, i_next, i_up, i_down, i_tick_1hz,
        input  o_run, o_set_mode, o_field, o_inc, o_dec, o_blank
    );

    modport slave (
        input  i_mode, i_next, i_up, i_down, i_tick_1hz,
        output o_run, o_set_mode, o_field, o_inc, o_dec, o_blank
    );
endinterface

// File: rtl/watch_set_cu.sv
// Time-setting control unit: RUN / SET_HOUR / SET_MIN / SET_SEC with inc/dec strobes,
// field blink for the display and an inactivity timeout back to RUN.
module watch_set_cu #(
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter int unsigned TIMEOUT_S  = 10
) (
    input  logic          clk,
    input  logic          rst,
    watch_set_cu_if.slave bus
);

    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned IDLE_W  = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_S - 1);

    // Encoding matches the o_field code of each state.
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOUR = 2'b01,
        ST_MIN  = 2'b10,
        ST_SEC  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [IDLE_W-1:0]  idle_q,  idle_d;
    logic               blank_q, blank_d;
    logic               inc_q,   inc_d;
    logic               dec_q,   dec_d;
    logic               run_q,   run_d;
    logic               set_q,   set_d;
    logic [1:0]         field_q, field_d;

    logic up_only;
    logic down_only;
    logic edit;

    always_comb begin
        state_d   = state_q;
        blink_d   = blink_q;
        idle_d    = idle_q;
        blank_d   = blank_q;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        up_only   = bus.i_up & ~bus.i_down;
        down_only = bus.i_down & ~bus.i_up;
        edit      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.i_mode) begin
                    state_d = ST_HOUR;
                end
            end
            default: begin
                // Priority: mode exit, then field advance, then a single up/down, then timeout.
                if (bus.i_mode) begin
                    state_d = ST_RUN;
                end else if (bus.i_next) begin
                    edit = 1'b1;
                    case (state_q)
                        ST_HOUR: state_d = ST_MIN;
                        ST_MIN:  state_d = ST_SEC;
                        default: state_d = ST_HOUR;
                    endcase
                end else if (up_only || down_only) begin
                    edit  = 1'b1;
                    inc_d = up_only;
                    dec_d = down_only;
                end else if (bus.i_tick_1hz && (idle_q == IDLE_LAST)) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        // Counters idle at zero in RUN and restart on entry or any accepted edit.
        if (state_d == ST_RUN || state_q == ST_RUN || edit) begin
            blink_d = '0;
            idle_d  = '0;
            blank_d = 1'b0;
        end else begin
            if (bus.i_tick_1hz) begin
                idle_d = idle_q + IDLE_W'(1);
            end
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                blank_d = ~blank_q;
            end else begin
                blink_d = blink_q + BLINK_W'(1);
            end
        end

        run_d   = (state_d == ST_RUN);
        set_d   = (state_d != ST_RUN);
        field_d = 2'(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            blink_q <= '0;
            idle_q  <= '0;
            blank_q <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            run_q   <= 1'b1;
            set_q   <= 1'b0;
            field_q <= 2'b00;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            idle_q  <= idle_d;
            blank_q <= blank_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            run_q   <= run_d;
            set_q   <= set_d;
            field_q <= field_d;
        end
    end

    assign bus.o_run      = run_q;
    assign bus.o_set_mode = set_q;
    assign bus.o_field    = field_q;
    assign bus.o_inc      = inc_q;
    assign bus.o_dec      = dec_q;
    assign bus.o_blank    = blank_q;

endmodule

// File: tb/tb_watch_set_cu.sv
// Bench for watch_set_cu: constant vector table, hand-written blink/timeout/reset sequences,
// and random pulses compared each cycle against an event-time reference model.
module tb_watch_set_cu;

    localparam int unsigned BH = 4;
    localparam int unsigned TO = 3;

    logic clk;
    logic rst;
    watch_set_cu_if bus ();

    watch_set_cu #(.BLINK_HALF(BH), .TIMEOUT_S(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model: in-set flag, field number, edge of last visibility restart, ticks since then.
    bit m_set;
    int m_field;
    int m_anchor;
    int m_ticks;
    int cyc;
    bit m_inc;
    bit m_dec;

    typedef struct {
        logic mode, next, up, down, tick;
        logic [6:0] exp;  // {run, set_mode, field[1:0], inc, dec, blank}
    } vec_t;

    vec_t vecs[14];

    function automatic logic [6:0] dut_out();
        return {bus.o_run, bus.o_set_mode, bus.o_field, bus.o_inc, bus.o_dec, bus.o_blank};
    endfunction

    function automatic logic [6:0] model_out();
        logic bl;
        bl = m_set && ((((cyc - m_anchor) / int'(BH)) % 2) == 1);
        return {~m_set, m_set, 2'(m_field), m_inc, m_dec, bl};
    endfunction

    task automatic model_exit();
        m_set   = 1'b0;
        m_field = 0;
        m_ticks = 0;
    endtask

    task automatic model_step(input logic m, n, u, d, t, r);
        cyc++;
        m_inc = 1'b0;
        m_dec = 1'b0;
        if (r) begin
            model_exit();
        end else if (!m_set) begin
            if (m) begin
                m_set    = 1'b1;
                m_field  = 1;
                m_anchor = cyc;
                m_ticks  = 0;
            end
        end else if (m) begin
            model_exit();
        end else if (n) begin
            m_field  = (m_field % 3) + 1;
            m_anchor = cyc;
            m_ticks  = 0;
        end else if (u != d) begin
            m_inc    = u;
            m_dec    = d;
            m_anchor = cyc;
            m_ticks  = 0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks >= int'(TO)) model_exit();
        end
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b (run,set,field,inc,dec,blank)", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, clock, advance model, sample 1 time unit after the edge.
    task automatic cycle(input logic m, n, u, d, t, r);
        bus.i_mode     = m;
        bus.i_next     = n;
        bus.i_up       = u;
        bus.i_down     = d;
        bus.i_tick_1hz = t;
        rst            = r;
        @(posedge clk);
        model_step(m, n, u, d, t, r);
        #1;
        chk("model", dut_out(), model_out());
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        m_anchor = 0;
        model_exit();
        m_inc = 0;
        m_dec = 0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0_1_01_000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0_1_10_000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0_1_11_000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0_1_01_000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1_0_00_000};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0_1_01_000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0_1_10_000};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0_1_10_100};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0_1_10_000};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0_1_10_000};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0_1_11_000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0_1_11_010};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1_0_00_000};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1_0_00_000};

        // Reset values, then idle and an ignored up pulse in RUN.
        do_reset();
        chk("reset", dut_out(), 7'b1_0_00_000);
        idle(20);
        chk("idle_run", dut_out(), 7'b1_0_00_000);
        cycle(0, 0, 1, 0, 0, 0);
        chk("up_in_run", dut_out(), 7'b1_0_00_000);

        // Vector table: field walk and coincident-input priority.
        foreach (vecs[i]) begin
            cycle(vecs[i].mode, vecs[i].next, vecs[i].up, vecs[i].down, vecs[i].tick, 1'b0);
            chk($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Blink period and restart after an edit.
        do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        idle(3);
        chk1("blink_pre", bus.o_blank, 1'b0);
        idle(1);
        chk1("blink_on", bus.o_blank, 1'b1);
        idle(2);
        cycle(0, 0, 1, 0, 0, 0);
        chk1("blink_edit_clr", bus.o_blank, 1'b0);
        chk1("blink_edit_inc", bus.o_inc, 1'b1);
        idle(3);
        chk1("blink_restart_pre", bus.o_blank, 1'b0);
        idle(1);
        chk1("blink_restart_on", bus.o_blank, 1'b1);
        idle(4);
        chk1("blink_off_again", bus.o_blank, 1'b0);

        // Timeout in SET_SEC: an edit restarts the tick count.
        do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("to_2ticks", dut_out() & 7'b1111_110, 7'b0_1_11_000);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk1("to_post2", bus.o_set_mode, 1'b1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("to_exit", dut_out(), 7'b1_0_00_000);

        // Tick coincident with up restarts the count.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 0, 1, 0);
        chk1("to_tick_up_inc", bus.o_inc, 1'b1);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk1("to_tick_up_hold", bus.o_set_mode, 1'b1);
        cycle(0, 0, 0, 0, 1, 0);
        chk1("to_tick_up_exit", bus.o_run, 1'b1);

        // Mode coincident with the timeout tick: single exit, no re-entry.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        chk1("to_mode_exit", bus.o_set_mode, 1'b0);
        idle(1);
        chk1("to_mode_stay", bus.o_set_mode, 1'b0);

        // Reset mid-edit with blank on and an up pulse.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        idle(4);
        chk("rst_pre", dut_out(), 7'b0_1_10_001);
        cycle(0, 0, 1, 0, 0, 1);
        chk("rst_mid_edit", dut_out(), 7'b1_0_00_000);

        // Random pulses against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 9) == 0),
                  logic'($urandom_range(0, 3) == 0),  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 4) == 0),  logic'($urandom_range(0, 299) == 0));
            tests++;
            if (bus.o_inc && bus.o_dec) begin
                fails++;
                $display("FAIL inc_dec_both cyc=%0d got=11 want=not both", cyc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
